// File: rtl/apb_initiator_pkg.sv
// -----------------------------------------------------------------------------
// apb_initiator_pkg
//   Shared definitions for the APB3 initiator: FSM state encoding and width.
//   Imported by apb_initiator and apb_initiator_wdog.
// -----------------------------------------------------------------------------
package apb_initiator_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage : apb_initiator_pkg

// File: rtl/apb_initiator_wdog.sv
// -----------------------------------------------------------------------------
// apb_initiator_wdog
//   Wait-state watchdog for the APB initiator ACCESS phase. Only instantiated
//   when APB_INITIATOR_TIMEOUT_EN is defined.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   pulse in the cycle before ACCESS is entered; clears count
//   access_wait  in   ACCESS cycle with PREADY low
//   expired      out  this waiting cycle is the TIMEOUT_CYCLES-th one
// -----------------------------------------------------------------------------
module apb_initiator_wdog
    import apb_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic access_wait,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = '0;
        end else if (access_wait && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of waiting cycles already completed, so the
    // cycle that would make the count reach TIMEOUT_CYCLES is the expiring one.
    // A PREADY in that cycle drops access_wait and therefore wins.
    assign expired = access_wait && (count_q == CNT_LAST);

endmodule : apb_initiator_wdog

// File: rtl/apb_initiator.sv
// -----------------------------------------------------------------------------
// apb_initiator
//   Single-outstanding APB3 initiator. Accepts commands on a valid/ready
//   stream, runs one SETUP/ACCESS transfer at a time and returns read data and
//   error status on a valid/ready response stream.
//
// Optional feature macro: APB_INITIATOR_TIMEOUT_EN
//   defined   : ACCESS aborts after TIMEOUT_CYCLES cycles without PREADY and
//               returns rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   undefined : ACCESS waits indefinitely, rsp_timeout is constant 0.
//
// Ports
//   PCLK, PRESET                  clock / asynchronous active-high reset
//   cmd_valid/ready               command handshake (cmd_ready combinational)
//   cmd_write, cmd_addr, cmd_wdata command fields
//   rsp_valid/ready               response handshake
//   rsp_rdata, rsp_err, rsp_timeout response fields (registered)
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA  APB requester outputs (registered)
//   PRDATA, PREADY, PSLVERR       APB completer inputs
// -----------------------------------------------------------------------------
module apb_initiator
    import apb_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_initiator: TIMEOUT_CYCLES must be at least 1");
    end

    state_e                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  accept;
    logic                  wd_expired;

`ifdef APB_INITIATOR_TIMEOUT_EN
    apb_initiator_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk         (PCLK),
        .rst         (PRESET),
        .start       (state_q == SETUP),
        .access_wait ((state_q == ACCESS) && !PREADY),
        .expired     (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // A new command can be taken while the previous response is being
    // consumed, which is what gives the 3-cycle back-to-back cadence.
    assign cmd_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d       = state_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_err_d     = PSLVERR;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (wd_expired) begin
                    rsp_err_d     = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (accept) begin
                        pwrite_d = cmd_write;
                        paddr_d  = cmd_addr;
                        pwdata_d = cmd_wdata;
                        state_d  = SETUP;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Control outputs are registered versions of the next-state decode so
        // they line up with the state they describe.
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef APB_INITIATOR_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    // Without the watchdog the flop only ever holds 0; drive the port as a
    // constant so the output is trivially 0.
    logic unused_timeout;
    assign unused_timeout = rsp_timeout_q;
    assign rsp_timeout    = 1'b0;
`endif

endmodule : apb_initiator

// File: tb/tb_apb_initiator.sv
// -----------------------------------------------------------------------------
// tb_apb_initiator
//   Self-checking bench for apb_initiator. Expected responses are pushed to a
//   scoreboard queue when a command is accepted and popped when the DUT
//   presents a response. Build with +define+APB_INITIATOR_TIMEOUT_EN to also
//   exercise the watchdog (TIMEOUT_CYCLES=4).
// -----------------------------------------------------------------------------
module tb_apb_initiator;

    localparam int AW = 8;
    localparam int DW = 32;

    typedef struct packed {
        logic          err;
        logic          tmo;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_a, acc_b;
    rsp_t sb[$];

    apb_initiator #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Present a command in the current cycle; it must be accepted now.
    task automatic issue(input string tag, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input rsp_t exp);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        #1;
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        sb.push_back(exp);
    endtask

    task automatic expect_rsp(input string tag);
        rsp_t e;
        check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        check({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_rsp_err"}, rsp_err, e.err);
            check({tag, "_rsp_timeout"}, rsp_timeout, e.tmo);
            check({tag, "_rsp_rdata"}, rsp_rdata, e.rdata);
        end
    endtask

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // ---------------- reset state
        repeat (2) tick();
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_paddr", PADDR, '0);
        check("rst_pwdata", PWDATA, '0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        check("rst_rsp_err", rsp_err, 1'b0);
        PRESET = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        tick();

        // ---------------- write 0x08 <- 5, PREADY high
        PREADY = 1'b1;
        issue("wr", 1'b1, 8'h08, 32'h0000_0005, '{err: 1'b0, tmo: 1'b0, rdata: '0});
        tick(); cmd_valid = 1'b0;                                     // cycle 1
        check("wr_c1_psel", PSEL, 1'b1);
        check("wr_c1_penable", PENABLE, 1'b0);
        tick();                                                       // cycle 2
        check("wr_c2_penable", PENABLE, 1'b1);
        check("wr_c2_paddr", PADDR, 8'h08);
        check("wr_c2_pwrite", PWRITE, 1'b1);
        check("wr_c2_pwdata", PWDATA, 32'h5);
        tick();                                                       // cycle 3
        expect_rsp("wr");
        check("wr_c3_psel", PSEL, 1'b0);
        tick();
        check("wr_done_valid", rsp_valid, 1'b0);
        check("wr_hold_paddr", PADDR, 8'h08);

        // ---------------- read 0x80 with three wait states
        PREADY  = 1'b0;
        PSLVERR = 1'b1;                 // noise: must not be sampled while waiting
        PRDATA  = 32'hDEAD_BEEF;
        issue("rd", 1'b0, 8'h80, 32'h1111_2222, '{err: 1'b0, tmo: 1'b0, rdata: 32'h7});
        tick(); cmd_valid = 1'b0;                                     // cycle 1
        check("rd_c1_paddr", PADDR, 8'h80);
        check("rd_c1_pwrite", PWRITE, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check($sformatf("rd_c%0d_paddr", c), PADDR, 8'h80);
            check($sformatf("rd_c%0d_penable", c), PENABLE, 1'b1);
            check($sformatf("rd_c%0d_valid", c), rsp_valid, 1'b0);
        end
        tick();                                                       // cycle 5
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = 32'h0000_0007;
        check("rd_c5_paddr", PADDR, 8'h80);
        check("rd_c5_penable", PENABLE, 1'b1);
        tick();                                                       // cycle 6
        expect_rsp("rd");
        tick();

        // ---------------- read with PSLVERR, response back-pressured
        rsp_ready = 1'b0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b1;
        PRDATA    = 32'h0000_1234;
        issue("err", 1'b0, 8'h40, '0, '{err: 1'b1, tmo: 1'b0, rdata: 32'h1234});
        tick(); cmd_valid = 1'b0;
        tick();
        tick();                                                       // cycle 3
        PSLVERR = 1'b0;
        PRDATA  = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("err_hold%0d_valid", i), rsp_valid, 1'b1);
            check($sformatf("err_hold%0d_err", i), rsp_err, 1'b1);
            check($sformatf("err_hold%0d_rdata", i), rsp_rdata, 32'h1234);
            check($sformatf("err_hold%0d_cmd_ready", i), cmd_ready, 1'b0);
            check($sformatf("err_hold%0d_psel", i), PSEL, 1'b0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("err_release_cmd_ready", cmd_ready, 1'b1);
        expect_rsp("err");
        tick();
        check("err_done_valid", rsp_valid, 1'b0);

        // ---------------- back-to-back: write then read
        PREADY = 1'b1;
        PRDATA = 32'h0000_0055;
        issue("b2b_a", 1'b1, 8'h10, 32'h0000_AAAA, '{err: 1'b0, tmo: 1'b0, rdata: '0});
        acc_a = cyc;
        tick();                                                       // cycle 1
        cmd_write = 1'b0;
        cmd_addr  = 8'h20;
        cmd_wdata = 32'h0;
        #1;
        check("b2b_c1_cmd_ready", cmd_ready, 1'b0);
        tick();                                                       // cycle 2
        check("b2b_c2_cmd_ready", cmd_ready, 1'b0);
        tick();                                                       // cycle 3
        expect_rsp("b2b_a");
        issue("b2b_b", 1'b0, 8'h20, 32'h0, '{err: 1'b0, tmo: 1'b0, rdata: 32'h55});
        acc_b = cyc;
        check("b2b_accept_gap", acc_b - acc_a, 3);
        tick(); cmd_valid = 1'b0;                                     // cycle 4
        check("b2b_c4_psel", PSEL, 1'b1);
        check("b2b_c4_penable", PENABLE, 1'b0);
        check("b2b_c4_paddr", PADDR, 8'h20);
        check("b2b_c4_valid", rsp_valid, 1'b0);
        tick();                                                       // cycle 5
        tick();                                                       // cycle 6
        expect_rsp("b2b_b");
        tick();

`ifdef APB_INITIATOR_TIMEOUT_EN
        // ---------------- timeout with PREADY held low
        PREADY = 1'b0;
        PRDATA = 32'h0000_0099;
        issue("tmo", 1'b0, 8'h44, '0, '{err: 1'b1, tmo: 1'b1, rdata: '0});
        tick(); cmd_valid = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            check($sformatf("tmo_c%0d_penable", c), PENABLE, 1'b1);
        end
        tick();                                                       // cycle 6
        expect_rsp("tmo");
        check("tmo_psel", PSEL, 1'b0);
        check("tmo_penable", PENABLE, 1'b0);
        tick();

        // ---------------- PREADY on the 4th ACCESS cycle wins
        issue("tmo_ok", 1'b0, 8'h48, '0, '{err: 1'b0, tmo: 1'b0, rdata: 32'h99});
        tick(); cmd_valid = 1'b0;
        tick(); tick(); tick();
        tick();                                                       // cycle 5
        PREADY = 1'b1;
        tick();                                                       // cycle 6
        expect_rsp("tmo_ok");
        tick();
`endif

        // ---------------- reset during ACCESS
        PREADY = 1'b0;
        issue("arst", 1'b0, 8'h30, '0, '{err: 1'b0, tmo: 1'b0, rdata: '0});
        tick(); cmd_valid = 1'b0;
        tick();                                                       // cycle 2
        check("arst_pre_penable", PENABLE, 1'b1);
        PRESET = 1'b1;
        #1;
        check("arst_psel", PSEL, 1'b0);
        check("arst_penable", PENABLE, 1'b0);
        check("arst_rsp_valid", rsp_valid, 1'b0);
        check("arst_rsp_rdata", rsp_rdata, '0);
        sb.delete();
        tick();
        PRESET = 1'b0;
        #1;
        check("arst_cmd_ready", cmd_ready, 1'b1);
        tick();
        check("arst_idle_valid", rsp_valid, 1'b0);

        PREADY = 1'b1;
        PRDATA = 32'h0000_003C;
        issue("post", 1'b0, 8'h0C, '0, '{err: 1'b0, tmo: 1'b0, rdata: 32'h3C});
        tick(); cmd_valid = 1'b0;
        tick();
        check("post_paddr", PADDR, 8'h0C);
        tick();
        expect_rsp("post");
        tick();
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_apb_initiator

// File: doc/apb_initiator.md
# apb_initiator

Single-outstanding APB3 initiator that turns a valid/ready command stream into APB transfers. It drives PSEL/PENABLE/PADDR/PWDATA/PWRITE toward one APB slave segment, such as the GPIO peripherals. It returns read data and error status on a valid/ready response stream. It sits between a bridge or sequencer and the APB peripheral fabric, and is the requester-side counterpart of the existing APB responders.

## Interface
- ADDR_WIDTH, 8: PADDR and cmd_addr width.
- DATA_WIDTH, 32: PWDATA, PRDATA, cmd_wdata and rsp_rdata width.
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles without PREADY before abort. Must be ≥1. Used only with the timeout feature.
- PCLK  in  1  clock; all logic rising-edge.
- PRESET  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR sampled, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH.
- PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- cmd_ready = (state==IDLE) || (state==RESP && rsp_ready). This is combinational from state and rsp_ready.
- IDLE: PSEL=0, PENABLE=0. On accept, register cmd_write, cmd_addr and cmd_wdata onto PWRITE, PADDR and PWDATA, then go to SETUP.
- SETUP: PSEL=1, PENABLE=0, lasting exactly one cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR, PWDATA and PWRITE stay stable throughout.
  - On PREADY=1: capture PSLVERR into rsp_err. Capture PRDATA into rsp_rdata for reads, or 0 for writes. Set rsp_timeout=0 and go to RESP.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1, with response fields held.
  - rsp_ready=1 with a new command accepted: go to SETUP.
  - rsp_ready=1 with no new command: go to IDLE.
  - rsp_ready=0: stay in RESP.
- PADDR, PWDATA and PWRITE keep their last values outside transfers.
- PSLVERR and PRDATA are sampled only in the ACCESS cycle where PREADY=1.
- Reset (async, any state): state goes to IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and rsp_timeout all go to 0. An in-flight transfer is dropped with no response. cmd_ready becomes 1 once PRESET deasserts.

## Timing
- Accept in cycle 0 → SETUP in cycle 1 → ACCESS in cycle 2.
- With PREADY=1 in cycle 2, rsp_valid=1 in cycle 3.
- Each PREADY=0 ACCESS cycle adds one cycle of latency.
- Back-to-back throughput with rsp_ready held 1 and PREADY=1: one transfer per 3 cycles.
- Every output is registered except cmd_ready.

## Configuration
- APB_INITIATOR_TIMEOUT_EN defined:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES with PREADY still 0, the next state is RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0. PSEL and PENABLE drop.
  - PREADY=1 in the same cycle as the counter reaching TIMEOUT_CYCLES wins: a normal completion.
- APB_INITIATOR_TIMEOUT_EN undefined: no counter. ACCESS waits indefinitely and rsp_timeout is tied to 0.

## Structure
- Shared package apb_initiator_pkg holds the state enum (IDLE, SETUP, ACCESS, RESP) and the state encoding width.
- Sub-module apb_initiator_wdog contains the timeout counter. It is instantiated only under APB_INITIATOR_TIMEOUT_EN.
  - Inputs: start (ACCESS entry), wait (ACCESS && !PREADY).
  - Output: expired.
- The FSM and datapath registers live in the top module.

## Test plan
- Write addr 0x08, data 0x0000_0005, PREADY held 1 → PSEL in cycle 1, PENABLE in cycle 2 with PADDR=0x08, PWRITE=1, PWDATA=5. rsp_valid in cycle 3 with rsp_err=0, rsp_rdata=0.
- Read addr 0x80, PREADY low for 3 ACCESS cycles, PRDATA=0x0000_0007 with PREADY=1 → rsp_rdata=7 in cycle 6. PADDR stable for cycles 1–5.
- Read with PSLVERR=1 at PREADY → rsp_err=1, rsp_timeout=0. With rsp_ready held 0 for 4 cycles, rsp_valid stays 1 with fields stable and cmd_ready=0.
- Two commands queued and rsp_ready held 1 → second SETUP in the same cycle the first response is consumed; accepts occur 3 cycles apart.
- With TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY held 0 → after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0, PSEL=0. Repeat with PREADY=1 on the 4th cycle → normal completion.
- Assert PRESET during ACCESS → same cycle PSEL=0, PENABLE=0, rsp_valid=0. After release, cmd_ready=1 and a new read completes normally.
